// File: rtl/acq_pkg.sv
// acq_pkg: shared constants, FSM state encoding and PRN helpers for the
// GPS C/A acquisition search sequencer.
//
// PRN encoding: a 5-bit field where 1..31 are literal and 0 stands for PRN 32.
// Ordering helpers treat the encoded 0 as the largest PRN.
package acq_pkg;

  localparam int CHIPS_PER_CODE = 1023;
  localparam int MAX_PHASE      = 1022;
  localparam int NUM_PRN        = 32;

  typedef logic [2:0] acq_state_t;

  localparam acq_state_t ST_IDLE   = 3'd0;
  localparam acq_state_t ST_CLEAR  = 3'd1;
  localparam acq_state_t ST_LOAD   = 3'd2;
  localparam acq_state_t ST_DWELL  = 3'd3;
  localparam acq_state_t ST_CHECK  = 3'd4;
  localparam acq_state_t ST_REPORT = 3'd5;
  localparam acq_state_t ST_FINISH = 3'd6;

  // Encoded PRN -> numeric PRN (1..32)
  function automatic logic [5:0] prn_rank(input logic [4:0] enc);
    return (enc == 5'd0) ? 6'(NUM_PRN) : {1'b0, enc};
  endfunction

  // True when PRN a comes after PRN b in sweep order
  function automatic logic prn_after(input logic [4:0] a, input logic [4:0] b);
    return prn_rank(a) > prn_rank(b);
  endfunction

  // Next PRN in sweep order; 31 rolls to the encoded 0 (PRN 32)
  function automatic logic [4:0] prn_inc(input logic [4:0] enc);
    return enc + 5'd1;
  endfunction

endpackage

// File: rtl/acq_search_ctrl_if.sv
// acq_search_ctrl_if: datapath-side bundle of the acquisition sequencer.
//   gen_load/gen_prn/gen_phase/gen_en : code generator control
//   corr_clr/corr_found               : correlator clear and found flag
//   res_valid/res_ready/res_*         : per-PRN result handshake
// master = sequencer, slave = generator/correlator/result consumer side.
interface acq_search_ctrl_if;

  logic       gen_load;
  logic [4:0] gen_prn;
  logic [9:0] gen_phase;
  logic       gen_en;
  logic       corr_clr;
  logic       corr_found;
  logic       res_valid;
  logic       res_ready;
  logic [4:0] res_prn;
  logic       res_found;
  logic [9:0] res_phase;

  modport master (
    output gen_load, gen_prn, gen_phase, gen_en, corr_clr,
    output res_valid, res_prn, res_found, res_phase,
    input  corr_found, res_ready
  );

  modport slave (
    input  gen_load, gen_prn, gen_phase, gen_en, corr_clr,
    input  res_valid, res_prn, res_found, res_phase,
    output corr_found, res_ready
  );

endinterface

// File: rtl/dwell_counter.sv
// dwell_counter: chip down-counter for one dwell.
//   clk, rst_n : clock, async active-low reset
//   clear      : reload to DWELL_CHIPS-1
//   enable     : count one chip
//   tc         : high on the DWELL_CHIPS-th enabled chip
module dwell_counter #(
  parameter int DWELL_CHIPS = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int W = (DWELL_CHIPS > 1) ? $clog2(DWELL_CHIPS) : 1;
  localparam logic [W-1:0] LOAD_VAL = W'(DWELL_CHIPS - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= LOAD_VAL;
    end else if (clear) begin
      cnt <= LOAD_VAL;
    end else if (enable && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign tc = enable && (cnt == '0);

endmodule

// File: rtl/acq_search_ctrl.sv
// acq_search_ctrl: sweeps PRN_FIRST..PRN_LAST and every code phase (step
// PHASE_STEP) per PRN; each trial clears the correlator, loads the code
// generator, runs one dwell and samples the found flag. One result per PRN
// is offered on a valid/ready handshake.
//   clk, rst_n          : clock, async active-low reset
//   start, abort        : host requests
//   prn_first, prn_last : sweep range (0 encodes PRN 32)
//   busy, done          : search status / end-of-search pulse
//   bus (master)        : generator, correlator and result signals
// Build option: ACQ_CONFIRM_EN -- a hit is only reported after a second
// dwell at the same phase also finds the code.
//
// state  | meaning
// IDLE   | waiting for start
// CLEAR  | correlator clear pulse
// LOAD   | generator load with (prn, phase)
// DWELL  | chip enable for DWELL_CHIPS chips
// CHECK  | sample found flag, pick next trial or report
// REPORT | result valid, wait for ready
// FINISH | done pulse
module acq_search_ctrl
  import acq_pkg::*;
#(
  parameter int PHASE_STEP  = 1,
  parameter int DWELL_CHIPS = CHIPS_PER_CODE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [4:0]        prn_first,
  input  logic [4:0]        prn_last,
  output logic              busy,
  output logic              done,
  acq_search_ctrl_if.master bus
);

  acq_state_t  state, state_nx;
  logic [4:0]  prn, prn_nx, last_q, last_nx;
  logic [9:0]  phase, phase_nx;
  logic [4:0]  res_prn_q, res_prn_nx;
  logic        res_found_q, res_found_nx;
  logic [9:0]  res_phase_q, res_phase_nx;
  logic [10:0] phase_sum;
  logic        dwell_tc, abort_take, first_hit, hit_final;

  dwell_counter #(.DWELL_CHIPS(DWELL_CHIPS)) u_dwell (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state != ST_DWELL),
    .enable (state == ST_DWELL),
    .tc     (dwell_tc)
  );

  // 11-bit sum so the range compare cannot wrap
  assign phase_sum = {1'b0, phase} + 11'(PHASE_STEP);

`ifdef ACQ_CONFIRM_EN
  logic confirm_q;

  // Set while the repeat dwell of a first-time hit is in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      confirm_q <= 1'b0;
    end else if (state == ST_IDLE) begin
      confirm_q <= 1'b0;
    end else if (state == ST_CHECK) begin
      confirm_q <= first_hit;
    end
  end

  assign first_hit = bus.corr_found && !confirm_q;
  assign hit_final = bus.corr_found && confirm_q;
`else
  assign first_hit = 1'b0;
  assign hit_final = bus.corr_found;
`endif

  always_comb begin
    state_nx     = state;
    prn_nx       = prn;
    phase_nx     = phase;
    last_nx      = last_q;
    res_prn_nx   = res_prn_q;
    res_found_nx = res_found_q;
    res_phase_nx = res_phase_q;
    abort_take   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          prn_nx   = prn_first;
          last_nx  = prn_last;
          phase_nx = '0;
          state_nx = prn_after(prn_first, prn_last) ? ST_FINISH : ST_CLEAR;
        end
      end
      ST_CLEAR: state_nx = ST_LOAD;
      ST_LOAD:  state_nx = ST_DWELL;
      ST_DWELL: begin
        if (dwell_tc) state_nx = ST_CHECK;
      end
      ST_CHECK: begin
        if (first_hit) begin
          state_nx = ST_CLEAR;
        end else if (hit_final) begin
          res_prn_nx   = prn;
          res_found_nx = 1'b1;
          res_phase_nx = phase;
          state_nx     = ST_REPORT;
        end else if (phase_sum <= 11'(MAX_PHASE)) begin
          phase_nx = phase_sum[9:0];
          state_nx = ST_CLEAR;
        end else begin
          res_prn_nx   = prn;
          res_found_nx = 1'b0;
          res_phase_nx = '0;
          state_nx     = ST_REPORT;
        end
      end
      ST_REPORT: begin
        if (bus.res_ready) begin
          if (prn == last_q) begin
            state_nx = ST_FINISH;
          end else begin
            prn_nx   = prn_inc(prn);
            phase_nx = '0;
            state_nx = ST_CLEAR;
          end
        end
      end
      ST_FINISH: state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
    if (abort && state != ST_IDLE) begin
      state_nx   = ST_IDLE;
      abort_take = 1'b1;
    end
  end

  // Strobes are registered from the next state so each lines up with its state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      prn           <= 5'd1;
      phase         <= '0;
      last_q        <= '0;
      res_prn_q     <= '0;
      res_found_q   <= 1'b0;
      res_phase_q   <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      bus.gen_load  <= 1'b0;
      bus.gen_en    <= 1'b0;
      bus.corr_clr  <= 1'b0;
      bus.res_valid <= 1'b0;
    end else begin
      state         <= state_nx;
      prn           <= prn_nx;
      phase         <= phase_nx;
      last_q        <= last_nx;
      res_prn_q     <= res_prn_nx;
      res_found_q   <= res_found_nx;
      res_phase_q   <= res_phase_nx;
      busy          <= (state_nx != ST_IDLE);
      done          <= (state_nx == ST_FINISH);
      bus.gen_load  <= (state_nx == ST_LOAD);
      bus.gen_en    <= (state_nx == ST_DWELL);
      bus.corr_clr  <= (state_nx == ST_CLEAR) || abort_take;
      bus.res_valid <= (state_nx == ST_REPORT);
    end
  end

  assign bus.gen_prn   = prn;
  assign bus.gen_phase = phase;
  assign bus.res_prn   = res_prn_q;
  assign bus.res_found = res_found_q;
  assign bus.res_phase = res_phase_q;

endmodule

// File: doc/acq_search_ctrl.md
# acq_search_ctrl

Sequencer for GPS C/A acquisition. It sweeps a PRN range and, for each PRN, every code phase in steps of PHASE_STEP chips. For each trial it clears the correlator, loads the Gold code generator with (PRN, phase), runs one dwell and samples the correlator's found flag. It reports one result per PRN to a downstream consumer through a valid/ready handshake, and sits between the host control registers and the code generator / correlator pair.

## Interface
- PHASE_STEP, 1: phase increment per trial, in chips (1..1022).
- DWELL_CHIPS, 1023: chips per dwell; must equal the correlator integration length.
- CLK  in  1  sample/chip clock.
- RESET_N  in  1  asynchronous, active-low reset.
- START  in  1  one-cycle request; latches PRN_FIRST/PRN_LAST.
- ABORT  in  1  abandon the search.
- PRN_FIRST  in  5  first PRN; 0 encodes PRN 32.
- PRN_LAST  in  5  last PRN, same encoding.
- BUSY  out  1  search in progress.
- DONE  out  1  one-cycle pulse at search end.
- GEN_LOAD  out  1  one-cycle load strobe to the code generator.
- GEN_PRN  out  5  PRN for the generator.
- GEN_PHASE  out  10  initial phase for the generator; also feeds the correlator's phase input.
- GEN_EN  out  1  chip enable; high only during a dwell.
- CORR_CLR  out  1  correlator clear; drives the correlator reset.
- CORR_FOUND  in  1  correlator found flag.
- RES_VALID  out  1  result valid.
- RES_READY  in  1  consumer accepts the result.
- RES_PRN  out  5  PRN of the result.
- RES_FOUND  out  1  1 = acquired.
- RES_PHASE  out  10  acquired phase; 0 when RES_FOUND = 0.

## Operation
- States: IDLE, CLEAR, LOAD, DWELL, CHECK, REPORT, FINISH.
- IDLE:
  - START moves to CLEAR, with prn = PRN_FIRST and phase = 0.
  - If PRN_FIRST > PRN_LAST (32 compares as the largest value), go directly to FINISH. No results are produced.
- CLEAR: CORR_CLR = 1 for one cycle.
- LOAD: GEN_LOAD = 1 for one cycle, with GEN_PRN = prn and GEN_PHASE = phase.
- DWELL: GEN_EN = 1. An internal chip counter counts 1..DWELL_CHIPS, then the state moves to CHECK.
- CHECK samples CORR_FOUND:
  - If 1: latch the result (found, phase), go to REPORT.
  - Else, if phase + PHASE_STEP ≤ 1022: phase += PHASE_STEP, go to CLEAR.
  - Else: latch the result (not found), go to REPORT.
- Phase arithmetic uses 11 bits, so the comparison cannot wrap. Phase is never greater than 1022.
- REPORT: RES_VALID = 1, and the RES_* fields stay stable until RES_READY.
  - On the handshake cycle: if prn == PRN_LAST go to FINISH. Otherwise prn += 1 (31 → 32 encoded as 0), phase = 0, go to CLEAR.
- FINISH: DONE = 1 for one cycle, then IDLE.
- BUSY = 1 in every state except IDLE.
- START while BUSY is ignored.
- ABORT (any state other than IDLE) takes priority over all transitions:
  - Next state is IDLE, with CORR_CLR = 1 for that one cycle.
  - No DONE pulse. A pending RES_VALID is dropped.
- ABORT and START in the same cycle in IDLE: START wins.

## Timing
- All outputs are registered.
- Reset values: BUSY = 0, DONE = 0, GEN_LOAD = 0, GEN_EN = 0, CORR_CLR = 0, RES_VALID = 0, GEN_PRN = 1, GEN_PHASE = 0, RES_PRN = 0, RES_FOUND = 0, RES_PHASE = 0.
- START at edge n gives BUSY = 1 and CORR_CLR = 1 after edge n+1.
- Each trial takes DWELL_CHIPS + 3 cycles (CLEAR, LOAD, dwell, CHECK). The default is 1026.
- RES_VALID rises the cycle after CHECK.
- DONE rises the cycle after the final handshake.
- Reset asserted mid-search returns the block to IDLE immediately. Output values are as listed above.

## Configuration
- `ACQ_CONFIRM_EN` defined:
  - A CHECK hit does not report directly. It goes to a CONFIRM path that repeats CLEAR/LOAD/DWELL at the same phase.
  - Acquisition is declared only if the second dwell is also found.
  - If the second dwell misses, the phase advances as for a miss.
  - A confirmed trial costs 2 × (DWELL_CHIPS + 3) cycles.
- Undefined: a single dwell hit is reported. No CONFIRM logic is synthesised.

## Structure
- Package acq_pkg:
  - State enum.
  - CHIPS_PER_CODE = 1023, MAX_PHASE = 1022, NUM_PRN = 32.
  - PRN encoding helpers (0 ↔ 32, comparison order).
- Sub-module dwell_counter:
  - Inputs: clear, enable.
  - Output: a terminal-count pulse at DWELL_CHIPS.

## Test plan
- PRN_FIRST = PRN_LAST = 5, correlator model hits at phase 17 → one result (5, 1, 17). DONE comes 18 × 1026 + 2 cycles after START, with RES_READY held high.
- PRN 1..3, no hits, PHASE_STEP = 2 → three results with RES_FOUND = 0 and RES_PHASE = 0. GEN_PHASE runs 0, 2, …, 1022 for each PRN.
- PRN_FIRST = 31, PRN_LAST = 0, hit on PRN 32 at phase 1022 → results for 31 (miss), then PRN field 0 (hit, phase 1022). The PRN increments 31 → 0.
- RES_READY held low for 50 cycles during REPORT → RES_* stay stable and no new CORR_CLR is issued; the search resumes on the handshake.
- ABORT in the middle of a dwell → IDLE next cycle with CORR_CLR pulsed, no DONE. A START 2 cycles later runs normally.
- With `ACQ_CONFIRM_EN`, a model that hits on the first dwell only, at phase 4 → no result at phase 4 and the sweep continues at phase 5.
